// File: rtl/serial_number_source.sv
// Serial byte receiver acting as the converter side of a soc/eoc handshake.
// One byte is captured per accepted soc; bad frames only raise ferr.
module serial_number_source #(
  parameter int BIT_TICKS = 16
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       rxd,
  input  logic       soc,
  output logic       eoc,
  output logic [7:0] numero,
  output logic       ferr
);

  typedef enum logic [2:0] {
    W_SOC,
    HUNT,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  localparam logic [15:0] FULL = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF = 16'(BIT_TICKS / 2 - 1);

  state_t      state_q, state_d;
  logic [15:0] tick_q, tick_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  numero_q, numero_d;
  logic        eoc_q, eoc_d;
  logic        ferr_q, ferr_d;
  logic        prev_q;

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q  <= W_SOC;
      tick_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      numero_q <= '0;
      eoc_q    <= 1'b1;
      ferr_q   <= 1'b0;
      prev_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      numero_q <= numero_d;
      eoc_q    <= eoc_d;
      ferr_q   <= ferr_d;
      prev_q   <= rxd;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    numero_d = numero_q;
    eoc_d    = eoc_q;
    ferr_d   = ferr_q;
    unique case (state_q)
      W_SOC: begin
        if (soc) begin
          eoc_d   = 1'b0;
          ferr_d  = 1'b0;
          state_d = HUNT;
        end
      end
      HUNT: begin
        if (!rxd && prev_q) begin
          tick_d  = HALF;
          state_d = START;
        end
      end
      START: begin
        if (tick_q == 16'd0) begin
          if (!rxd) begin
            tick_d  = FULL;
            bit_d   = 4'd0;
            state_d = DATA;
          end else begin
            state_d = HUNT;
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      DATA: begin
        if (tick_q == 16'd0) begin
          shift_d = {rxd, shift_q[7:1]};
          tick_d  = FULL;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd7) begin
            state_d = STOP;
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      STOP: begin
        if (tick_q == 16'd0) begin
          if (rxd) begin
            state_d = DONE;
          end else begin
            ferr_d  = 1'b1;
            state_d = HUNT;
          end
        end else begin
          tick_d = tick_q - 16'd1;
        end
      end
      DONE: begin
        // hold the byte back until the consumer has released soc
        if (!soc) begin
          numero_d = shift_q;
          eoc_d    = 1'b1;
          state_d  = W_SOC;
        end
      end
      default: state_d = W_SOC;
    endcase
  end

  assign eoc    = eoc_q;
  assign numero = numero_q;
  assign ferr   = ferr_q;

endmodule
